// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, power-up blanking and a
// per-channel STABLE/FILTER machine producing a filtered level plus edge pulses.
module key_debounce_multi #(
    parameter int   N_CH         = 4,
    parameter int   DB_CYCLES    = 500000,
    parameter int   BLANK_CYCLES = 5000,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [N_CH-1:0] Pin_In,
    output logic [N_CH-1:0] Key_Level,
    output logic [N_CH-1:0] H2L_Sig,
    output logic [N_CH-1:0] L2H_Sig,
    output logic            Ready
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic {ST_STABLE, ST_FILTER} state_e;

    logic [N_CH-1:0] s1_q, s2_q;
    logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
    logic            ready_q, ready_d;
    state_e          state_q [N_CH];
    state_e          state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [N_CH-1:0] lvl_q, lvl_d;
    logic [N_CH-1:0] h2l_q, h2l_d;
    logic [N_CH-1:0] l2h_q, l2h_d;

    // Blanking counter saturates at BLANK_LAST; Ready is sticky until reset.
    always_comb begin
        blank_cnt_d = blank_cnt_q;
        ready_d     = ready_q;
        if (!ready_q) begin
            if (blank_cnt_q == BLANK_LAST) begin
                ready_d = 1'b1;
            end else begin
                blank_cnt_d = blank_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        h2l_d = '0;
        l2h_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!ready_q) begin
                // Adopt the true pin level silently while blanking.
                state_d[i] = ST_STABLE;
                cnt_d[i]   = '0;
                lvl_d[i]   = s2_q[i];
            end else begin
                case (state_q[i])
                    ST_STABLE: begin
                        if (s2_q[i] != lvl_q[i]) begin
                            cnt_d[i]   = CW'(1);
                            state_d[i] = ST_FILTER;
                        end
                    end
                    ST_FILTER: begin
                        if (s2_q[i] == lvl_q[i]) begin
                            cnt_d[i]   = '0;
                            state_d[i] = ST_STABLE;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            lvl_d[i]   = s2_q[i];
                            h2l_d[i]   = ~s2_q[i];
                            l2h_d[i]   = s2_q[i];
                            cnt_d[i]   = '0;
                            state_d[i] = ST_STABLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        cnt_d[i]   = '0;
                        state_d[i] = ST_STABLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1_q        <= {N_CH{IDLE_LEVEL}};
            s2_q        <= {N_CH{IDLE_LEVEL}};
            blank_cnt_q <= '0;
            ready_q     <= 1'b0;
            lvl_q       <= {N_CH{IDLE_LEVEL}};
            h2l_q       <= '0;
            l2h_q       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q        <= Pin_In;
            s2_q        <= s1_q;
            blank_cnt_q <= blank_cnt_d;
            ready_q     <= ready_d;
            lvl_q       <= lvl_d;
            h2l_q       <= h2l_d;
            l2h_q       <= l2h_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign Key_Level = lvl_q;
    assign H2L_Sig   = h2l_q;
    assign L2H_Sig   = l2h_q;
    assign Ready     = ready_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi (N_CH=4, DB_CYCLES=8, BLANK_CYCLES=16).
module tb_key_debounce_multi;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [3:0] Pin_In = 4'b1110;
    logic [3:0] Key_Level, H2L_Sig, L2H_Sig;
    logic       Ready;

    int tests = 0;
    int fails = 0;
    int h2l_n [4];
    int l2h_n [4];
    bit mon_en = 1'b0;

    key_debounce_multi #(
        .N_CH(4), .DB_CYCLES(8), .BLANK_CYCLES(16), .IDLE_LEVEL(1'b1)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Pin_In(Pin_In),
        .Key_Level(Key_Level), .H2L_Sig(H2L_Sig), .L2H_Sig(L2H_Sig), .Ready(Ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] pin;
        int         n;
        logic [3:0] lvl;
        logic [3:0] h2l;
        logic [3:0] l2h;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] lvl, input logic [3:0] h2l,
                           input logic [3:0] l2h, input logic rdy);
        chk({name, " lvl"}, Key_Level, lvl);
        chk({name, " h2l"}, H2L_Sig, h2l);
        chk({name, " l2h"}, L2H_Sig, l2h);
        chk({name, " rdy"}, {3'b000, Ready}, {3'b000, rdy});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Continuous monitor: no pulses while blanking, never both edges on one channel.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (!Ready) chk("blank quiet", H2L_Sig | L2H_Sig, 4'b0000);
            chk("edge exclusive", H2L_Sig & L2H_Sig, 4'b0000);
            for (int c = 0; c < 4; c++) begin
                if (H2L_Sig[c]) h2l_n[c]++;
                if (L2H_Sig[c]) l2h_n[c]++;
            end
        end
    end

    initial begin
        int h0;
        for (int c = 0; c < 4; c++) begin
            h2l_n[c] = 0;
            l2h_n[c] = 0;
        end

        // Power-up blanking, then ch1 fall, ch2 glitches, ch0/ch3 together, ch1 rise.
        vecs.push_back('{4'b1110, 15, 4'b1110, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{4'b1110,  1, 4'b1110, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{4'b1110,  3, 4'b1110, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{4'b1100,  9, 4'b1110, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{4'b1100,  1, 4'b1100, 4'b0010, 4'b0000, 1'b1});
        vecs.push_back('{4'b1100,  1, 4'b1100, 4'b0000, 4'b0000, 1'b1});
        for (int r = 0; r < 3; r++) begin
            vecs.push_back('{4'b1000, 7, 4'b1100, 4'b0000, 4'b0000, 1'b1});
            vecs.push_back('{4'b1100, 2, 4'b1100, 4'b0000, 4'b0000, 1'b1});
        end
        vecs.push_back('{4'b1100, 12, 4'b1100, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{4'b0101,  9, 4'b1100, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{4'b0101,  1, 4'b0101, 4'b1000, 4'b0001, 1'b1});
        vecs.push_back('{4'b0101,  1, 4'b0101, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{4'b0111, 10, 4'b0111, 4'b0000, 4'b0010, 1'b1});
        vecs.push_back('{4'b0111,  1, 4'b0111, 4'b0000, 4'b0000, 1'b1});

        mon_en = 1'b1;
        step(3);
        chk_all("reset", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        RSTn = 1'b1;

        foreach (vecs[i]) begin
            Pin_In = vecs[i].pin;
            step(vecs[i].n);
            chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].h2l, vecs[i].l2h, vecs[i].rdy);
        end
        chk_int("ch2 glitch pulses", h2l_n[2] + l2h_n[2], 0);

        // Bounce train on ch1: low 3, high 1, low 5, high 1, low held.
        h0 = h2l_n[1];
        Pin_In = 4'b0101; step(3);
        Pin_In = 4'b0111; step(1);
        Pin_In = 4'b0101; step(5);
        Pin_In = 4'b0111; step(1);
        Pin_In = 4'b0101; step(9);
        chk_all("bounce pre", 4'b0111, 4'b0000, 4'b0000, 1'b1);
        step(1);
        chk_all("bounce commit", 4'b0101, 4'b0010, 4'b0000, 1'b1);
        step(1);
        chk_all("bounce after", 4'b0101, 4'b0000, 4'b0000, 1'b1);
        chk_int("bounce pulse count", h2l_n[1] - h0, 1);

        // Reset in the middle of a ch2 FILTER (cnt=6 after the 8th edge).
        Pin_In = 4'b0001;
        step(8);
        RSTn = 1'b0;
        #1;
        chk_all("mid reset", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        step(2);
        RSTn = 1'b1;
        step(15);
        chk_all("reblank", 4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(1);
        chk_all("reready", 4'b0001, 4'b0000, 4'b0000, 1'b1);
        step(12);
        chk_all("post reset", 4'b0001, 4'b0000, 4'b0000, 1'b1);
        chk_int("ch2 stale pulses", h2l_n[2] + l2h_n[2], 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
